neuron_mac_stage: RTL

Sequential multiply-accumulate neuron that produces the signed Q4.4 pre-activation value z_value, which the LUT/interpolator activation stage consumes directly.
- Input/weight pairs are streamed one per cycle; the block accumulates N_INPUTS products, adds a bias, rescales, saturates and presents one 8-bit result.
- It sits between the layer's input/weight sequencer and the activation function of the same neuron.

---
 rtl/neuron_mac_stage.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/neuron_mac_stage.sv
// ---------------------------------------------------------------------------
// neuron_mac_stage
//
// Sequential multiply-accumulate stage of one neuron. Streams N_INPUTS signed
// Q4.4 x/w pairs, one per accepted handshake. Each full-precision product is
// summed into a wide accumulator. The bias is then added, the sum is rescaled
// back to Q4.4 and saturated. The 8-bit result is held on z_value until the
// activation stage takes it.
//
// Handshakes (both sides): a transfer happens on a rising clk edge where
// valid && ready are both high. The producer holds its data stable while valid
// is high and ready is low. in_ready and out_valid are functions of the FSM
// state only, and never depend on in_valid or out_ready.
//
// Ports
//   clk        : system clock, rising edge
//   rst        : asynchronous active-low reset
//   in_valid   : x/w pair presented
//   in_ready   : block can accept a pair this cycle (ACC state)
//   x, w       : signed Q4.4 activation / weight
//   bias       : signed Q4.4 bias, stable from the first accepted pair to out_valid
//   out_valid  : z_value holds a result that has not been consumed yet
//   out_ready  : downstream accepts z_value
//   z_value    : signed saturated pre-activation, Q4.4
//   count      : pairs accepted for the current result
//   fsm_state  : current FSM state (debug): 0=ACC, 1=FIN, 2=OUT
// ---------------------------------------------------------------------------
module neuron_mac_stage #(
  parameter int N_INPUTS  = 4,
  parameter int DATA_W    = 8,
  parameter int FRAC_BITS = 4,
  parameter int ACC_W     = 20,
  localparam int CNT_W    = $clog2(N_INPUTS + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] x,
  input  logic signed [DATA_W-1:0] w,
  input  logic signed [DATA_W-1:0] bias,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] z_value,
  output logic [CNT_W-1:0]         count,
  output logic [1:0]               fsm_state
);

  localparam int PROD_W = 2 * DATA_W;

  typedef enum logic [1:0] {
    ST_ACC = 2'd0,
    ST_FIN = 2'd1,
    ST_OUT = 2'd2
  } state_t;

  // Count value at which the accepted pair is the last one of the result.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_INPUTS - 1);

  // Saturation bounds of the DATA_W-bit signed result, widened to ACC_W.
  localparam logic signed [ACC_W-1:0] Z_MAX_W =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] Z_MIN_W =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic signed [DATA_W-1:0] Z_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] Z_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  state_t                    state;
  logic signed [ACC_W-1:0]   acc;

  logic signed [PROD_W-1:0]  prod;
  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [ACC_W-1:0]   bias_ext;
  logic signed [ACC_W-1:0]   bias_scaled;
  logic signed [ACC_W-1:0]   sum;
  logic signed [ACC_W-1:0]   q;
  logic signed [DATA_W-1:0]  z_sat;
  logic                      in_fire;
  logic                      out_fire;

  assign in_ready  = (state == ST_ACC);
  assign fsm_state = state;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready && (state == ST_OUT);

  // Datapath: full-width product, bias alignment to the product's Q format,
  // floor rescale (arithmetic shift rounds toward -inf), then clamp.
  always_comb begin
    prod        = x * w;
    prod_ext    = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    bias_ext    = {{(ACC_W-DATA_W){bias[DATA_W-1]}}, bias};
    bias_scaled = bias_ext <<< FRAC_BITS;
    sum         = acc + bias_scaled;
    q           = sum >>> FRAC_BITS;
    z_sat       = q[DATA_W-1:0];
    if (q > Z_MAX_W) begin
      z_sat = Z_MAX;
    end else if (q < Z_MIN_W) begin
      z_sat = Z_MIN;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_ACC;
      acc       <= '0;
      count     <= '0;
      z_value   <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_ACC: begin
          if (in_fire) begin
            acc   <= acc + prod_ext;
            count <= count + 1'b1;
            if (count == LAST_CNT) begin
              state <= ST_FIN;
            end
          end
        end
        ST_FIN: begin
          z_value   <= z_sat;
          out_valid <= 1'b1;
          state     <= ST_OUT;
        end
        ST_OUT: begin
          // z_value is not cleared here. It keeps the last result until
          // the next FIN overwrites it.
          if (out_fire) begin
            out_valid <= 1'b0;
            acc       <= '0;
            count     <= '0;
            state     <= ST_ACC;
          end
        end
        default: begin
          state <= ST_ACC;
        end
      endcase
    end
  end

endmodule
